// File: rtl/ttt_phase_scheduler_if.sv
// Handshake and status bundle for the tick/tock phase scheduler.
// master = environment side, slave = scheduler side.
interface ttt_phase_scheduler_if #(
  parameter int ADDR_W = 3
) ();
  logic              ena;
  logic              start;
  logic              ext_valid;
  logic              ext_ready;
  logic [ADDR_W-1:0] ext_addr;
  logic              fb_valid;
  logic              fb_ready;
  logic [ADDR_W-1:0] fb_addr;
  logic              tok_valid;
  logic [ADDR_W-1:0] tok_addr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [1:0]        phase;
  logic              busy;
  logic              done;

  modport master (
    output ena, start,
    output ext_valid, ext_addr,
    output fb_valid, fb_addr,
    input  ext_ready, fb_ready,
    input  tok_valid, tok_addr,
    input  upd_valid, upd_addr,
    input  phase, busy, done
  );

  modport slave (
    input  ena, start,
    input  ext_valid, ext_addr,
    input  fb_valid, fb_addr,
    output ext_ready, fb_ready,
    output tok_valid, tok_addr,
    output upd_valid, upd_addr,
    output phase, busy, done
  );
endinterface

// File: rtl/ttt_phase_scheduler.sv
// Tick/tock phase scheduler: TICK accepts tokens from two sources
// with round-robin arbitration, TOCK sweeps an update over every processor.
module ttt_phase_scheduler #(
  parameter int NUM_PROCESSORS = 8,
  parameter int TICK_MAX       = 16,
  localparam int ADDR_W = $clog2(NUM_PROCESSORS)
) (
  input logic clk,
  input logic rst_n,
  ttt_phase_scheduler_if.slave bus
);

  localparam int CNT_W = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_TICK = 2'b01;
  localparam logic [1:0] S_TOCK = 2'b10;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TICK_MAX - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST =
    ADDR_W'(NUM_PROCESSORS - 1);

  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              last_ext_q, last_ext_d;
  logic              tok_valid_q, tok_valid_d;
  logic [ADDR_W-1:0] tok_addr_q, tok_addr_d;
  logic              upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  logic              done_q, done_d;

  logic in_tick;
  logic grant_ext;
  logic grant_fb;

  // Arbitration: lone requester wins; on contention the source
  // not granted last time wins.
  always_comb begin
    in_tick   = bus.ena && (phase_q == S_TICK);
    grant_fb  = in_tick && bus.fb_valid &&
                (!bus.ext_valid || last_ext_q);
    grant_ext = in_tick && bus.ext_valid &&
                (!bus.fb_valid || !last_ext_q);
  end

  // Phase sequencing, tick counting and update sweep.
  always_comb begin
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    last_ext_d  = last_ext_q;
    tok_valid_d = 1'b0;
    tok_addr_d  = tok_addr_q;
    upd_valid_d = 1'b0;
    upd_addr_d  = upd_addr_q;
    done_d      = 1'b0;
    if (bus.ena) begin
      unique case (1'b1)
        (phase_q == S_IDLE): begin
          if (bus.start) begin
            phase_d = S_TICK;
            cnt_d   = '0;
          end
        end
        (phase_q == S_TICK): begin
          if (grant_ext || grant_fb) begin
            tok_valid_d = 1'b1;
            tok_addr_d  = grant_fb ? bus.fb_addr
                                   : bus.ext_addr;
            last_ext_d  = grant_ext;
          end
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end
          if ((!bus.ext_valid && !bus.fb_valid) ||
              (cnt_q == CNT_LAST)) begin
            phase_d = S_TOCK;
            idx_d   = '0;
          end
        end
        (phase_q == S_TOCK): begin
          upd_valid_d = 1'b1;
          upd_addr_d  = idx_q;
          idx_d       = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            phase_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          phase_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset abandons any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      last_ext_q  <= 1'b1;
      tok_valid_q <= 1'b0;
      tok_addr_q  <= '0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      last_ext_q  <= last_ext_d;
      tok_valid_q <= tok_valid_d;
      tok_addr_q  <= tok_addr_d;
      upd_valid_q <= upd_valid_d;
      upd_addr_q  <= upd_addr_d;
      done_q      <= done_d;
    end
  end

  assign bus.ext_ready = grant_ext;
  assign bus.fb_ready  = grant_fb;
  assign bus.tok_valid = tok_valid_q;
  assign bus.tok_addr  = tok_addr_q;
  assign bus.upd_valid = upd_valid_q;
  assign bus.upd_addr  = upd_addr_q;
  assign bus.phase     = phase_q;
  assign bus.busy      = (phase_q != S_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ttt_phase_scheduler.sv
// Directed bench for ttt_phase_scheduler (N=8, TICK_MAX=16).
// Expected values are hand-derived per scenario.
module tb_ttt_phase_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ttt_phase_scheduler_if #(.ADDR_W(3)) bus ();

  ttt_phase_scheduler #(
    .NUM_PROCESSORS(8),
    .TICK_MAX(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called while the observed phase is TOCK with index = first.
  task automatic run_tock(input int first);
    for (int i = first; i < 8; i++) begin
      step();
      chk("upd_valid", int'(bus.upd_valid), 1);
      chk("upd_addr", int'(bus.upd_addr), i);
      chk("done", int'(bus.done), (i == 7) ? 1 : 0);
      chk("tock_phase", int'(bus.phase),
          (i == 7) ? 0 : 2);
      chk("tock_ext_rdy", int'(bus.ext_ready), 0);
      chk("tock_fb_rdy", int'(bus.fb_ready), 0);
    end
  endtask

  initial begin
    int fc;
    int ec;
    int toks;
    int n;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.ena   = 1'b0;
    bus.start = 1'b0;
    bus.ext_valid = 1'b0;
    bus.ext_addr  = '0;
    bus.fb_valid  = 1'b0;
    bus.fb_addr   = '0;
    step();
    step();
    chk("rst_phase", int'(bus.phase), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_tok_v", int'(bus.tok_valid), 0);
    chk("rst_upd_v", int'(bus.upd_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_upd_a", int'(bus.upd_addr), 0);
    rst_n   = 1'b1;
    bus.ena = 1'b1;
    step();

    // Empty cycle; start held across TOCK is taken from IDLE.
    bus.start = 1'b1;
    step();
    chk("e_tick", int'(bus.phase), 1);
    chk("e_busy", int'(bus.busy), 1);
    bus.start = 1'b0;
    #1;
    chk("e_ext_rdy", int'(bus.ext_ready), 0);
    chk("e_fb_rdy", int'(bus.fb_ready), 0);
    step();
    chk("e_tock", int'(bus.phase), 2);
    chk("e_upd0", int'(bus.upd_valid), 0);
    bus.start = 1'b1;
    run_tock(0);
    step();
    chk("e_restart", int'(bus.phase), 1);
    chk("e_post_upd", int'(bus.upd_valid), 0);
    chk("e_post_done", int'(bus.done), 0);
    bus.start = 1'b0;
    step();
    chk("e_tock2", int'(bus.phase), 2);
    run_tock(0);
    step();
    chk("e_idle", int'(bus.phase), 0);
    chk("e_end_upd", int'(bus.upd_valid), 0);
    chk("e_end_done", int'(bus.done), 0);

    // Contention: fb first, then alternate.
    fc = 0;
    ec = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("c_tick", int'(bus.phase), 1);
    for (int k = 0; k < 8; k++) begin
      bus.fb_valid  = (fc < 4);
      bus.fb_addr   = 3'(fc);
      bus.ext_valid = (ec < 4);
      bus.ext_addr  = 3'(4 + ec);
      #1;
      chk("c_fb_rdy", int'(bus.fb_ready),
          (k % 2 == 0) ? 1 : 0);
      chk("c_ext_rdy", int'(bus.ext_ready),
          (k % 2 == 1) ? 1 : 0);
      step();
      chk("c_tok_v", int'(bus.tok_valid), 1);
      chk("c_tok_a", int'(bus.tok_addr),
          (k % 2 == 0) ? (k / 2) : (4 + k / 2));
      if (k % 2 == 0) fc++;
      else ec++;
    end
    bus.fb_valid  = 1'b0;
    bus.ext_valid = 1'b0;
    step();
    chk("c_tock", int'(bus.phase), 2);
    chk("c_tok_off", int'(bus.tok_valid), 0);
    run_tock(0);

    // Timeout: ext stuck valid.
    bus.ext_valid = 1'b1;
    bus.ext_addr  = 3'd5;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t_tick", int'(bus.phase), 1);
    toks = 0;
    n    = 0;
    while (bus.phase == 2'b01 && n < 40) begin
      step();
      n++;
      if (bus.tok_valid) toks++;
    end
    chk("t_exit", int'(bus.phase), 2);
    chk("t_tokens", toks, 16);
    chk("t_tok_a", int'(bus.tok_addr), 5);
    chk("t_rdy_low", int'(bus.ext_ready), 0);
    bus.ext_valid = 1'b0;
    run_tock(0);

    // Stall for 3 cycles after upd_addr 3.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("s_tock", int'(bus.phase), 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s_upd_v", int'(bus.upd_valid), 1);
      chk("s_upd_a", int'(bus.upd_addr), i);
    end
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_stall_v", int'(bus.upd_valid), 0);
      chk("s_stall_d", int'(bus.done), 0);
      chk("s_stall_ph", int'(bus.phase), 2);
    end
    bus.ena = 1'b1;
    run_tock(4);

    // Feedback raised during TOCK waits for next TICK.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("d_tock", int'(bus.phase), 2);
    bus.fb_valid = 1'b1;
    bus.fb_addr  = 3'd6;
    run_tock(0);
    #1;
    chk("d_idle_rdy", int'(bus.fb_ready), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    #1;
    chk("d_fb_rdy", int'(bus.fb_ready), 1);
    chk("d_ext_rdy", int'(bus.ext_ready), 0);
    step();
    chk("d_tok_v", int'(bus.tok_valid), 1);
    chk("d_tok_a", int'(bus.tok_addr), 6);
    bus.fb_valid = 1'b0;
    step();
    chk("d_tock2", int'(bus.phase), 2);
    run_tock(0);

    // Reset at TOCK index 5.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("r_upd_a", int'(bus.upd_addr), i);
    end
    rst_n = 1'b0;
    #1;
    chk("r_phase", int'(bus.phase), 0);
    chk("r_busy", int'(bus.busy), 0);
    chk("r_upd_v", int'(bus.upd_valid), 0);
    chk("r_upd_a0", int'(bus.upd_addr), 0);
    chk("r_tok_a0", int'(bus.tok_addr), 0);
    chk("r_done", int'(bus.done), 0);
    step();
    step();
    chk("r_hold_done", int'(bus.done), 0);
    rst_n = 1'b1;
    step();
    chk("r_idle", int'(bus.phase), 0);

    // First contention after reset goes to fb.
    bus.fb_valid  = 1'b1;
    bus.fb_addr   = 3'd2;
    bus.ext_valid = 1'b1;
    bus.ext_addr  = 3'd3;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    #1;
    chk("p_fb_rdy", int'(bus.fb_ready), 1);
    chk("p_ext_rdy", int'(bus.ext_ready), 0);
    step();
    chk("p_tok_a0", int'(bus.tok_addr), 2);
    bus.fb_valid = 1'b0;
    #1;
    chk("p_ext_rdy2", int'(bus.ext_ready), 1);
    step();
    chk("p_tok_a1", int'(bus.tok_addr), 3);
    bus.ext_valid = 1'b0;
    step();
    chk("p_tock", int'(bus.phase), 2);
    run_tock(0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
